// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers (shift-add multiply, restoring divide).
// Define MULDIV_SIGNED_EN to enable signed MULT/DIV (Signal 24/26).
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] Output
);

  localparam logic [5:0] FnMultu = 6'd25;
  localparam logic [5:0] FnDivu  = 6'd27;
  localparam logic [5:0] FnMfhi  = 6'd16;
  localparam logic [5:0] FnMthi  = 6'd17;
  localparam logic [5:0] FnMflo  = 6'd18;
  localparam logic [5:0] FnMtlo  = 6'd19;
`ifdef MULDIV_SIGNED_EN
  localparam logic [5:0] FnMult  = 6'd24;
  localparam logic [5:0] FnDiv   = 6'd26;
`endif

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   hi, lo;
  logic [WIDTH-1:0]   opa, opb;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic               op_div;
  logic               b_zero;
`ifdef MULDIV_SIGNED_EN
  logic               neg_res;
  logic               neg_rem;
`endif

  // Decode of the launch request
  logic sig_legal, sig_div, sig_signed;
  always_comb begin
    sig_legal  = 1'b0;
    sig_div    = 1'b0;
    sig_signed = 1'b0;
    case (Signal)
      FnMultu: sig_legal = 1'b1;
      FnDivu: begin
        sig_legal = 1'b1;
        sig_div   = 1'b1;
      end
`ifdef MULDIV_SIGNED_EN
      FnMult: begin
        sig_legal  = 1'b1;
        sig_signed = 1'b1;
      end
      FnDiv: begin
        sig_legal  = 1'b1;
        sig_div    = 1'b1;
        sig_signed = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Operand magnitudes fed to the unsigned engine
  logic [WIDTH-1:0] mag_a, mag_b;
`ifdef MULDIV_SIGNED_EN
  assign mag_a = (sig_signed && dataA[WIDTH-1]) ? (~dataA + 1'b1) : dataA;
  assign mag_b = (sig_signed && dataB[WIDTH-1]) ? (~dataB + 1'b1) : dataB;
`else
  assign mag_a = dataA;
  assign mag_b = dataB;
  logic unused_signed;
  assign unused_signed = sig_signed;
`endif

  // Shift-add step: add multiplicand into the upper half when the current multiplier bit is set
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opa} : '0);

  // Restoring step: diff[WIDTH] set means the trial subtraction went negative
  logic [WIDTH:0]   rem_sh, diff;
  logic [WIDTH-1:0] rem_nx;
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, opb};
  assign rem_nx = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];

  // Final HI/LO values with sign fix-up
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic [WIDTH-1:0]   fix_q, fix_r;
  logic [2*WIDTH-1:0] fix_p;
  always_comb begin
    fix_q = quo;
    fix_r = rem;
    fix_p = prod;
`ifdef MULDIV_SIGNED_EN
    // On divide by zero the quotient stays all ones; the remainder un-negates back to dataA
    if (neg_res && !b_zero) fix_q = ~quo + 1'b1;
    if (neg_rem)            fix_r = ~rem + 1'b1;
    if (neg_res)            fix_p = ~prod + 1'b1;
`endif
    if (op_div) begin
      res_hi = fix_r;
      res_lo = fix_q;
    end else begin
      res_hi = fix_p[2*WIDTH-1:WIDTH];
      res_lo = fix_p[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= StIdle;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      opa      <= '0;
      opb      <= '0;
      prod     <= '0;
      rem      <= '0;
      quo      <= '0;
      op_div   <= 1'b0;
      b_zero   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            if (sig_legal) begin
              opa    <= mag_a;
              opb    <= mag_b;
              prod   <= {{WIDTH{1'b0}}, mag_b};
              quo    <= mag_a;
              rem    <= '0;
              op_div <= sig_div;
              b_zero <= (dataB == '0);
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= StRun;
`ifdef MULDIV_SIGNED_EN
              neg_res <= sig_signed & (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
              neg_rem <= sig_signed & dataA[WIDTH-1];
`endif
            end else if (Signal == FnMthi) begin
              hi <= dataA;
            end else if (Signal == FnMtlo) begin
              lo <= dataA;
            end
          end
        end
        StRun: begin
          if (op_div) begin
            rem <= rem_nx;
            quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
          end else begin
            prod <= {mul_sum, prod[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == LastCnt) state <= StFin;
        end
        StFin: begin
          hi    <= res_hi;
          lo    <= res_lo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= StIdle;
          if (op_div) div_zero <= b_zero;
        end
        default: state <= StIdle;
      endcase
    end
  end

  always_comb begin
    Output = '0;
    if (Signal == FnMfhi)      Output = hi;
    else if (Signal == FnMflo) Output = lo;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed scenarios plus random ops against a plain-arithmetic model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [5:0]   Signal;
  logic [W-1:0] dataA, dataB, Output;
  logic         busy, done, div_zero;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic         m_dz = 1'b0;

  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .Signal(Signal), .dataA(dataA), .dataB(dataB),
    .busy(busy), .done(done), .div_zero(div_zero), .Output(Output)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: results straight from integer arithmetic
  task automatic model_op(input logic [5:0] sig, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    longint sp;
    int sa, sb;
    case (sig)
      6'd25: begin
        p = {32'b0, a} * {32'b0, b};
        m_hi = p[2*W-1:W]; m_lo = p[W-1:0];
      end
      6'd27: begin
        if (b == 0) begin m_lo = '1; m_hi = a; m_dz = 1'b1; end
        else begin m_lo = a / b; m_hi = a % b; m_dz = 1'b0; end
      end
      6'd24: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        p = sp;
        m_hi = p[2*W-1:W]; m_lo = p[W-1:0];
      end
      6'd26: begin
        if (b == 0) begin m_lo = '1; m_hi = a; m_dz = 1'b1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = a; m_hi = '0; m_dz = 1'b0;
        end else begin
          sa = $signed(a); sb = $signed(b);
          m_lo = sa / sb; m_hi = sa % sb; m_dz = 1'b0;
        end
      end
      default: ;
    endcase
  endtask

  // Launch one op, wait (bounded) for done, then read HI/LO through Output
  task automatic run_op(input logic [5:0] sig, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int cyc, output int bcyc,
                        output logic [W-1:0] hi, output logic [W-1:0] lo);
    @(negedge clk);
    Signal = sig; dataA = a; dataB = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dataA = $urandom; dataB = $urandom;
    cyc = 0; bcyc = 0;
    while (!done && cyc < 100) begin
      if (busy) bcyc++;
      @(negedge clk);
      cyc++;
    end
    Signal = 6'd16; #1 hi = Output;
    Signal = 6'd18; #1 lo = Output;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; Signal = 6'd16; dataA = '0; dataB = '0;
    #3;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (div_zero !== 1'b0) begin miscompares++; $display("FAIL reset_dz: got %b want 0", div_zero); end
    vectors++; if (Output !== '0) begin miscompares++; $display("FAIL reset_hi: got %h want 0", Output); end
    Signal = 6'd18; #1;
    vectors++; if (Output !== '0) begin miscompares++; $display("FAIL reset_lo: got %h want 0", Output); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_divu_basic();
    int cyc, bcyc; logic [W-1:0] hi, lo;
    run_op(6'd27, 100, 7, cyc, bcyc, hi, lo);
    model_op(6'd27, 100, 7);
    vectors++; if (cyc != 33) begin miscompares++; $display("FAIL divu_latency: got %0d want 33", cyc); end
    vectors++; if (bcyc != 33) begin miscompares++; $display("FAIL divu_busy_cycles: got %0d want 33", bcyc); end
    vectors++; if (hi !== 32'd2) begin miscompares++; $display("FAIL divu_hi: got %h want 2", hi); end
    vectors++; if (lo !== 32'd14) begin miscompares++; $display("FAIL divu_lo: got %h want e", lo); end
    @(negedge clk);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL done_pulse_width: got %b want 0", done); end
  endtask

  task automatic test_multu_divzero();
    int cyc, bcyc; logic [W-1:0] hi, lo;
    run_op(6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, bcyc, hi, lo);
    vectors++; if (hi !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL multu_max_hi: got %h want fffffffe", hi); end
    vectors++; if (lo !== 32'h1) begin miscompares++; $display("FAIL multu_max_lo: got %h want 1", lo); end
    vectors++; if (cyc != 33) begin miscompares++; $display("FAIL multu_latency: got %0d want 33", cyc); end
    run_op(6'd27, 5, 0, cyc, bcyc, hi, lo);
    vectors++; if (lo !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL div0_lo: got %h want ffffffff", lo); end
    vectors++; if (hi !== 32'd5) begin miscompares++; $display("FAIL div0_hi: got %h want 5", hi); end
    vectors++; if (div_zero !== 1'b1) begin miscompares++; $display("FAIL div0_flag: got %b want 1", div_zero); end
    run_op(6'd25, 3, 3, cyc, bcyc, hi, lo);
    vectors++; if (div_zero !== 1'b1) begin miscompares++; $display("FAIL dz_sticky_mul: got %b want 1", div_zero); end
    run_op(6'd27, 9, 3, cyc, bcyc, hi, lo);
    model_op(6'd27, 9, 3);
    vectors++; if (div_zero !== 1'b0) begin miscompares++; $display("FAIL dz_clear: got %b want 0", div_zero); end
    vectors++; if (lo !== 32'd3) begin miscompares++; $display("FAIL divu_9_3_lo: got %h want 3", lo); end
  endtask

  task automatic test_busy_ignore();
    int cyc, bcyc, n, bad; logic [W-1:0] hi, lo;
    run_op(6'd25, 7, 6, cyc, bcyc, hi, lo);
    vectors++; if (lo !== 32'd42) begin miscompares++; $display("FAIL multu_7_6: got %h want 2a", lo); end
    @(negedge clk);
    Signal = 6'd27; dataA = 50; dataB = 5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    Signal = 6'd25; dataA = 3; dataB = 3; start = 1'b1;
    @(negedge clk); start = 1'b0; Signal = 6'd18; #1;
    vectors++; if (Output !== 32'd42) begin miscompares++; $display("FAIL mflo_during_run: got %h want 2a", Output); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_during_run: got %b want 1", busy); end
    n = 0;
    while (!done && n < 60) begin @(negedge clk); n++; end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL busy_ign_done: got %b want 1", done); end
    Signal = 6'd18; #1;
    vectors++; if (Output !== 32'd10) begin miscompares++; $display("FAIL busy_ign_lo: got %h want a", Output); end
    Signal = 6'd16; #1;
    vectors++; if (Output !== 32'd0) begin miscompares++; $display("FAIL busy_ign_hi: got %h want 0", Output); end
    bad = 0;
    repeat (40) begin @(negedge clk); if (busy || done) bad++; end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL no_queued_op: got %0d active samples want 0", bad); end
    model_op(6'd27, 50, 5);
  endtask

  task automatic test_mthi_mtlo();
    int dseen;
    dseen = 0;
    @(negedge clk); Signal = 6'd17; dataA = 32'h1234; start = 1'b1;
    @(negedge clk); if (done) dseen++; Signal = 6'd19; dataA = 32'hABCD;
    @(negedge clk); if (done) dseen++; start = 1'b0; Signal = 6'd0;
    repeat (3) begin @(negedge clk); if (done || busy) dseen++; end
    Signal = 6'd16; #1;
    vectors++; if (Output !== 32'h1234) begin miscompares++; $display("FAIL mthi: got %h want 1234", Output); end
    Signal = 6'd18; #1;
    vectors++; if (Output !== 32'hABCD) begin miscompares++; $display("FAIL mtlo: got %h want abcd", Output); end
    vectors++; if (dseen != 0) begin miscompares++; $display("FAIL mt_no_done: got %0d want 0", dseen); end
    Signal = 6'd0; #1;
    vectors++; if (Output !== '0) begin miscompares++; $display("FAIL output_other_fn: got %h want 0", Output); end
    m_hi = 32'h1234; m_lo = 32'hABCD;
  endtask

  task automatic test_illegal();
    int bad;
    bad = 0;
    @(negedge clk); Signal = 6'd16; dataA = 32'h55; dataB = 32'h3; start = 1'b1;
    @(negedge clk); Signal = 6'd5;
`ifndef MULDIV_SIGNED_EN
    @(negedge clk); if (busy) bad++; Signal = 6'd26;
    @(negedge clk); if (busy) bad++; Signal = 6'd24;
`endif
    @(negedge clk); if (busy) bad++; start = 1'b0;
    repeat (3) begin @(negedge clk); if (busy || done) bad++; end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL illegal_start: got %0d busy samples want 0", bad); end
    Signal = 6'd16; #1;
    vectors++; if (Output !== m_hi) begin miscompares++; $display("FAIL illegal_hi_kept: got %h want %h", Output, m_hi); end
  endtask

  task automatic test_async_reset();
    int cyc, bcyc; logic [W-1:0] hi, lo;
    run_op(6'd27, 77, 0, cyc, bcyc, hi, lo);
    vectors++; if (hi !== 32'd77) begin miscompares++; $display("FAIL pre_reset_div0_hi: got %h want 4d", hi); end
    @(negedge clk); Signal = 6'd27; dataA = 1000; dataB = 3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (14) @(negedge clk);
    #2 reset = 1'b1; Signal = 6'd16;
    #1;
    vectors++; if (Output !== '0) begin miscompares++; $display("FAIL async_rst_hi: got %h want 0", Output); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL async_rst_busy: got %b want 0", busy); end
    vectors++; if (div_zero !== 1'b0) begin miscompares++; $display("FAIL async_rst_dz: got %b want 0", div_zero); end
    Signal = 6'd18; #1;
    vectors++; if (Output !== '0) begin miscompares++; $display("FAIL async_rst_lo: got %h want 0", Output); end
    @(negedge clk); reset = 1'b0;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    run_op(6'd27, 100, 7, cyc, bcyc, hi, lo);
    model_op(6'd27, 100, 7);
    vectors++; if (cyc != 33) begin miscompares++; $display("FAIL post_rst_latency: got %0d want 33", cyc); end
    vectors++; if (hi !== m_hi) begin miscompares++; $display("FAIL post_rst_hi: got %h want %h", hi, m_hi); end
    vectors++; if (lo !== m_lo) begin miscompares++; $display("FAIL post_rst_lo: got %h want %h", lo, m_lo); end
  endtask

  task automatic test_signed();
    int cyc, bcyc; logic [W-1:0] hi, lo;
`ifdef MULDIV_SIGNED_EN
    run_op(6'd26, -32'sd7, 32'd2, cyc, bcyc, hi, lo);
    model_op(6'd26, -32'sd7, 32'd2);
    vectors++; if (lo !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL div_m7_2_lo: got %h want fffffffd", lo); end
    vectors++; if (hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL div_m7_2_hi: got %h want ffffffff", hi); end
    vectors++; if (cyc != 33) begin miscompares++; $display("FAIL signed_latency: got %0d want 33", cyc); end
    run_op(6'd24, -32'sd3, 32'd4, cyc, bcyc, hi, lo);
    vectors++; if (hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL mult_m3_4_hi: got %h want ffffffff", hi); end
    vectors++; if (lo !== 32'hFFFF_FFF4) begin miscompares++; $display("FAIL mult_m3_4_lo: got %h want fffffff4", lo); end
    run_op(6'd26, 32'h8000_0000, 32'hFFFF_FFFF, cyc, bcyc, hi, lo);
    vectors++; if (lo !== 32'h8000_0000) begin miscompares++; $display("FAIL div_min_m1_lo: got %h want 80000000", lo); end
    vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL div_min_m1_hi: got %h want 0", hi); end
    run_op(6'd26, -32'sd9, 32'd0, cyc, bcyc, hi, lo);
    vectors++; if (lo !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL sdiv0_lo: got %h want ffffffff", lo); end
    vectors++; if (hi !== 32'hFFFF_FFF7) begin miscompares++; $display("FAIL sdiv0_hi: got %h want fffffff7", hi); end
    model_op(6'd26, -32'sd9, 32'd0);
`else
    int bad;
    bad = 0;
    @(negedge clk); Signal = 6'd26; dataA = 32'hFFFF_FFF9; dataB = 2; start = 1'b1;
    @(negedge clk); start = 1'b0; if (busy) bad++;
    repeat (35) begin @(negedge clk); if (busy || done) bad++; end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL div_disabled: got %0d busy samples want 0", bad); end
    Signal = 6'd18; #1;
    vectors++; if (Output !== m_lo) begin miscompares++; $display("FAIL div_disabled_lo: got %h want %h", Output, m_lo); end
    cyc = 0; bcyc = 0; hi = '0; lo = '0;
`endif
  endtask

  task automatic test_random();
    int cyc, bcyc, nops; logic [W-1:0] hi, lo, a, b; logic [5:0] sig;
`ifdef MULDIV_SIGNED_EN
    nops = 4;
`else
    nops = 2;
`endif
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, nops - 1))
        0: sig = 6'd25;
        1: sig = 6'd27;
        2: sig = 6'd24;
        default: sig = 6'd26;
      endcase
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = $urandom_range(1, 300);
        2: b = -$urandom_range(1, 300);
        default: b = $urandom;
      endcase
      run_op(sig, a, b, cyc, bcyc, hi, lo);
      model_op(sig, a, b);
      vectors++; if (hi !== m_hi) begin miscompares++; $display("FAIL rand_hi[%0d] fn=%0d a=%h b=%h: got %h want %h", i, sig, a, b, hi, m_hi); end
      vectors++; if (lo !== m_lo) begin miscompares++; $display("FAIL rand_lo[%0d] fn=%0d a=%h b=%h: got %h want %h", i, sig, a, b, lo, m_lo); end
      vectors++; if (div_zero !== m_dz) begin miscompares++; $display("FAIL rand_dz[%0d]: got %b want %b", i, div_zero, m_dz); end
      vectors++; if (cyc != 33) begin miscompares++; $display("FAIL rand_latency[%0d]: got %0d want 33", i, cyc); end
    end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_multu_divzero();
    test_busy_ignore();
    test_mthi_mtlo();
    test_illegal();
    test_async_reset();
    test_signed();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO result registers. Generalises the fixed 32-bit DIVU-only path.
- Adds unsigned multiply, a start/busy/done handshake, divide-by-zero flagging, and MTHI/MTLO writes.
- Signed MULT/DIV are available as a compile option.
- Sits beside the combinational ALU in the EX stage. The ALU top muxes Output from this block for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand, HI and LO width; must be >= 4.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  launch request; sampled at posedge
- Signal  in  6  function code: 24 MULT, 25 MULTU, 26 DIV, 27 DIVU, 16 MFHI, 17 MTHI, 18 MFLO, 19 MTLO
- dataA  in  WIDTH  multiplicand / dividend / MTHI-MTLO source
- dataB  in  WIDTH  multiplier / divisor
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse; HI/LO updated at the same edge
- div_zero  out  1  sticky flag: last divide had dataB==0
- Output  out  WIDTH  combinational: HI when Signal==16, LO when Signal==18, 0 otherwise

Behaviour:
- Reset (async, any time including mid-operation): state=IDLE, HI=0, LO=0, busy=0, done=0, div_zero=0, counter=0. Any in-flight operation is discarded.
- FSM states: IDLE, RUN, FIN.
- IDLE→RUN: at a posedge with start=1 and a legal arithmetic Signal (25/27, plus 24/26 when signed ops are enabled).
  - dataA and dataB are latched; counter=0; busy=1 from that edge.
- RUN: one iteration per cycle, WIDTH cycles; RUN→FIN when counter==WIDTH-1.
  - MULTU: shift-add; product accumulator is 2*WIDTH bits.
  - DIVU: restoring, one quotient bit per cycle; remainder register is WIDTH+1 bits.
- FIN (1 cycle): sign fix-up if signed, then write HI/LO. done=1 in the cycle after that edge, busy=0. FIN→IDLE.
- Latency: start sampled at edge E0; HI/LO valid and done high after edge E0+WIDTH+1.
  - WIDTH=32 gives 33 cycles.
- Results:
  - MULT/MULTU: {HI,LO} = full 2*WIDTH product.
  - DIV/DIVU: LO = quotient, HI = remainder.
- Divide by zero: LO = all ones, HI = dataA (unsigned path result, no fix-up); div_zero=1 at the FIN edge.
  - div_zero is cleared at the FIN edge of the next divide with a nonzero divisor.
  - Multiplies do not touch div_zero.
- MTHI/MTLO (17/19): single-cycle write of dataA into HI/LO at the posedge with start=1, in IDLE only. done is not pulsed.
- start while busy: ignored. No queueing, no effect on the running operation.
- start with an illegal Signal: ignored. Stays IDLE.
- MFHI/MFLO while busy: Output returns HI/LO from the last completed operation.
- Operands are latched at the start edge. dataA/dataB changing during RUN has no effect.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined:
  - Signal 24/26 are legal.
  - Operands are converted to magnitudes at latch; the unsigned engine runs unchanged.
  - FIN negates the product if signA^signB.
  - For divide: quotient negated if signA^signB; remainder takes the sign of the dividend.
  - MIN/-1 gives LO=MIN, HI=0.
  - Signed divide by zero: LO=all ones, HI=dataA.
  - Latency is identical to the unsigned ops.
- Undefined: Signal 24/26 are treated as illegal (start ignored). No sign logic is synthesised.

Test Plan:
- DIVU 100/7, WIDTH=32 → done exactly 33 cycles after the start edge; MFHI Output=2, MFLO Output=14; busy high for 33 cycles.
- MULTU 0xFFFFFFFF*0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; then DIVU 5/0 → LO=0xFFFFFFFF, HI=5, div_zero=1; then DIVU 9/3 → div_zero=0.
- Start DIVU 50/5, pulse start with MULTU 3*3 at cycle 10, read MFLO during RUN → second start ignored; Output=previous LO during RUN; final LO=10, HI=0.
- MTHI 0x1234 then MTLO 0xABCD in IDLE → Output 0x1234/0xABCD on next MFHI/MFLO; done never pulses.
- Assert reset at cycle 15 of a DIVU → HI=LO=0 immediately (async); busy=0; a new start one cycle after reset release completes normally.
- MULDIV_SIGNED_EN: DIV -7/2 → LO=-3, HI=-1; MULT -3*4 → {HI,LO}=-12 sign-extended; DIV 0x80000000/-1 → LO=0x80000000, HI=0. Without the macro: start with Signal=26 → busy stays 0.
